filt_out_formatter: RTL and testbench

- Downstream stage of filter_lut in the 2D FIR datapath.
- Takes the 12-bit sign-magnitude filtop stream and aligns it with the input valid using a latency-matched delay line.
- Converts each sample to two's complement, rounds and shifts it, then clamps it to an 8-bit pixel.
- Tags raster position (start-of-frame, end-of-line) and buffers results in a small FIFO for a ready/valid consumer.

---
 rtl/filt_pkg.sv | 48 ++++
 rtl/filt_out_formatter_if.sv | 26 ++
 rtl/filt_out_fifo.sv | 62 ++++++
 rtl/filt_out_formatter.sv | 121 ++++++++++++
 tb/tb_filt_out_formatter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/filt_pkg.sv
// Shared types and arithmetic helpers for the 2D FIR output formatter.
// The conversion and clamp functions are also used by reference models.
package filt_pkg;

  localparam int FILT_W = 12;
  localparam int PIX_W  = 8;

  typedef logic signed [FILT_W:0] ext_t;

  typedef struct packed {
    logic             sat;
    logic [PIX_W-1:0] pix;
  } clamp_t;

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic             sat;
    logic [PIX_W-1:0] pix;
  } fifo_entry_t;

  // Negative zero falls out as 0 because -0 == 0.
  function automatic logic signed [FILT_W-1:0] sm_to_tc(input logic [FILT_W-1:0] sm);
    logic signed [FILT_W-1:0] mag;
    mag = $signed({1'b0, sm[FILT_W-2:0]});
    if (sm[FILT_W-1]) begin
      return -mag;
    end else begin
      return mag;
    end
  endfunction

  function automatic clamp_t clamp_pix(input ext_t v);
    clamp_t r;
    if (v < 13'sd0) begin
      r.sat = 1'b1;
      r.pix = 8'd0;
    end else if (v > 13'sd255) begin
      r.sat = 1'b1;
      r.pix = 8'd255;
    end else begin
      r.sat = 1'b0;
      r.pix = v[PIX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/filt_out_formatter_if.sv
// Stream bundle of the output formatter: sign-magnitude samples in,
// tagged pixels out through a ready/valid port.
interface filt_out_formatter_if;
  import filt_pkg::*;

  logic              in_valid;
  logic [FILT_W-1:0] filtop;
  logic [PIX_W-1:0]  out_pix;
  logic              out_sof;
  logic              out_eol;
  logic              out_sat;
  logic              out_valid;
  logic              out_ready;
  logic              ovf;

  modport master (
    input  in_valid, filtop, out_ready,
    output out_pix, out_sof, out_eol, out_sat, out_valid, ovf
  );

  modport slave (
    output in_valid, filtop, out_ready,
    input  out_pix, out_sof, out_eol, out_sat, out_valid, ovf
  );

endinterface

// File: rtl/filt_out_fifo.sv
// First-word fall-through FIFO; head is always visible on rdata while not empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module filt_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == '0);
  assign rdata = mem_r[rd_ptr_r];

  // Qualify requests against the current occupancy.
  always_comb begin
    do_pop_s  = pop && (count_r != '0);
    do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/filt_out_formatter.sv
// Aligns filter_lut output with its input valid, converts to a clamped 8-bit
// pixel tagged with raster position, and buffers it for a ready/valid consumer.
module filt_out_formatter
  import filt_pkg::*;
#(
  parameter int FILT_LAT   = 2,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int SHIFT      = 0,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  filt_out_formatter_if.master bus
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  // Half an output LSB, zero when no shift is applied.
  localparam ext_t RND = ext_t'((32'sd1 <<< SHIFT) >>> 1);

  logic [FILT_LAT-1:0]      dv_r;
  logic                     dv_s;
  logic [COL_W-1:0]         col_r;
  logic [ROW_W-1:0]         row_r;
  logic                     s1_valid_r;
  logic [FILT_W-1:0]        s1_data_r;
  logic                     s1_sof_r;
  logic                     s1_eol_r;
  logic                     s2_valid_r;
  fifo_entry_t              s2_entry_r;
  logic signed [FILT_W-1:0] tc_s;
  ext_t                     ext_s;
  ext_t                     rnd_s;
  clamp_t                   clamp_s;
  fifo_entry_t              head_s;
  logic                     fifo_pop_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic                     drop_s;
  logic                     ovf_r;

  assign dv_s = dv_r[FILT_LAT-1];

  // Stage-2 datapath: two's complement, round-half-up shift, clamp.
  always_comb begin
    tc_s    = sm_to_tc(s1_data_r);
    ext_s   = {tc_s[FILT_W-1], tc_s};
    rnd_s   = (ext_s + RND) >>> SHIFT;
    clamp_s = clamp_pix(rnd_s);
  end

  // Valid delay line, raster counters, pipeline registers and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_r       <= '0;
      col_r      <= '0;
      row_r      <= '0;
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
      s1_sof_r   <= 1'b0;
      s1_eol_r   <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_entry_r <= '0;
      ovf_r      <= 1'b0;
    end else begin
      dv_r       <= FILT_LAT'({dv_r, bus.in_valid});
      s1_valid_r <= dv_s;
      if (dv_s) begin
        s1_data_r <= bus.filtop;
        s1_sof_r  <= (row_r == '0) && (col_r == '0);
        s1_eol_r  <= (col_r == COL_LAST);
        if (col_r == COL_LAST) begin
          col_r <= '0;
          if (row_r == ROW_LAST) begin
            row_r <= '0;
          end else begin
            row_r <= row_r + ROW_W'(1);
          end
        end else begin
          col_r <= col_r + COL_W'(1);
        end
      end
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_entry_r <= '{sof: s1_sof_r, eol: s1_eol_r, sat: clamp_s.sat, pix: clamp_s.pix};
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // A full FIFO still accepts the push when the consumer pops in the same cycle.
  assign fifo_pop_s = bus.out_ready && !fifo_empty_s;
  assign drop_s     = s2_valid_r && fifo_full_s && !fifo_pop_s;

  filt_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_valid_r),
    .wdata (s2_entry_r),
    .pop   (fifo_pop_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign bus.out_pix   = head_s.pix;
  assign bus.out_sof   = head_s.sof;
  assign bus.out_eol   = head_s.eol;
  assign bus.out_sat   = head_s.sat;
  assign bus.out_valid = !fifo_empty_s;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_filt_out_formatter.sv
// Directed bench: dut_a (SHIFT=0, 8x8) and dut_b (SHIFT=2, 4x2), FILT_LAT=2, depth 4.
// filtop for a sample is driven FILT_LAT cycles after its in_valid, like filter_lut.
module tb_filt_out_formatter;
  import filt_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  filt_out_formatter_if a_if ();
  filt_out_formatter_if b_if ();

  filt_out_formatter #(
    .FILT_LAT(2), .IMG_W(8), .IMG_H(8), .SHIFT(0), .FIFO_DEPTH(4)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  filt_out_formatter #(
    .FILT_LAT(2), .IMG_W(4), .IMG_H(2), .SHIFT(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [11:0] a_vals [5] = '{12'h805, 12'h800, 12'h7FF, 12'h0FF, 12'h100};
  logic [7:0]  a_pix  [5] = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd255};
  logic        a_sat  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  logic [11:0] b_vals [10] = '{12'h00E, 12'h80E, 12'h00A, 12'h3FF, 12'h3FD,
                               12'h002, 12'h001, 12'h801, 12'h802, 12'h803};
  logic [7:0]  b_pix  [10] = '{8'd4, 8'd0, 8'd3, 8'd255, 8'd255,
                               8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
  logic        b_sat  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        b_sof  [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        b_eol  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.filtop = 12'h000; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.filtop = 12'h000; b_if.out_ready = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst_pix",   32'(a_if.out_pix),   32'd0);
    chk("rst_sof",   32'(a_if.out_sof),   32'd0);
    chk("rst_ovf",   32'(a_if.ovf),       32'd0);
    rst = 1'b0;
    step();

    // Single sample: sampled at edge k, visible after edge k+4.
    a_if.in_valid = 1'b1; a_if.filtop = 12'h064;
    step();
    a_if.in_valid = 1'b0;
    step(); step(); step();
    chk("lat_early_valid", 32'(a_if.out_valid), 32'd0);
    step();
    chk("lat_valid", 32'(a_if.out_valid), 32'd1);
    chk("lat_pix",   32'(a_if.out_pix),   32'd100);
    chk("lat_sat",   32'(a_if.out_sat),   32'd0);
    chk("lat_sof",   32'(a_if.out_sof),   32'd1);
    chk("lat_eol",   32'(a_if.out_eol),   32'd0);
    step();
    chk("lat_drained", 32'(a_if.out_valid), 32'd0);

    // Conversion and clamp corners, SHIFT=0.
    for (int t = 0; t < 10; t++) begin
      a_if.in_valid = (t < 5);
      a_if.filtop   = 12'h000;
      if (t >= 2 && t < 7) a_if.filtop = a_vals[t-2];
      step();
      if (t >= 4 && t < 9) begin
        chk("conv_valid", 32'(a_if.out_valid), 32'd1);
        chk("conv_pix",   32'(a_if.out_pix),   32'(a_pix[t-4]));
        chk("conv_sat",   32'(a_if.out_sat),   32'(a_sat[t-4]));
      end
    end

    // Rounding shift and raster tags on a 4x2 frame.
    for (int t = 0; t < 15; t++) begin
      b_if.in_valid = (t < 10);
      b_if.filtop   = 12'h000;
      if (t >= 2 && t < 12) b_if.filtop = b_vals[t-2];
      step();
      if (t >= 4 && t < 14) begin
        chk("shift_valid", 32'(b_if.out_valid), 32'd1);
        chk("shift_pix",   32'(b_if.out_pix),   32'(b_pix[t-4]));
        chk("shift_sat",   32'(b_if.out_sat),   32'(b_sat[t-4]));
        chk("raster_sof",  32'(b_if.out_sof),   32'(b_sof[t-4]));
        chk("raster_eol",  32'(b_if.out_eol),   32'(b_eol[t-4]));
      end
    end

    // Overflow: consumer stalled, six samples into a four-entry FIFO.
    a_if.out_ready = 1'b0;
    for (int t = 0; t < 12; t++) begin
      a_if.in_valid = (t < 6);
      a_if.filtop   = 12'h000;
      if (t >= 2 && t < 8) a_if.filtop = 12'(16 * (t - 1));
      step();
      if (t == 7) chk("ovf_before_drop", 32'(a_if.ovf), 32'd0);
      if (t == 8) chk("ovf_on_drop",     32'(a_if.ovf), 32'd1);
    end
    chk("ovf_hold_valid", 32'(a_if.out_valid), 32'd1);
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(a_if.out_valid), 32'd1);
      chk("drain_pix",   32'(a_if.out_pix),   32'(16 * (i + 1)));
      step();
    end
    chk("drain_empty", 32'(a_if.out_valid), 32'd0);
    chk("ovf_sticky",  32'(a_if.ovf),       32'd1);

    // Reset with samples in flight discards them and restarts the raster.
    for (int t = 0; t < 3; t++) begin
      a_if.in_valid = 1'b1;
      a_if.filtop   = 12'h123;
      step();
    end
    a_if.in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(a_if.out_valid), 32'd0);
    chk("mid_rst_ovf",   32'(a_if.ovf),       32'd0);
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      step();
      chk("flushed_valid", 32'(a_if.out_valid), 32'd0);
    end
    a_if.in_valid = 1'b1;
    a_if.filtop   = 12'h005;
    step();
    a_if.in_valid = 1'b0;
    step(); step(); step();
    chk("post_rst_early", 32'(a_if.out_valid), 32'd0);
    step();
    chk("post_rst_valid", 32'(a_if.out_valid), 32'd1);
    chk("post_rst_sof",   32'(a_if.out_sof),   32'd1);
    chk("post_rst_pix",   32'(a_if.out_pix),   32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
